// File: rtl/usb_pd_bmc_tx.sv
// USB-PD BMC line transmitter: preamble, LSB-first 4b5b symbol serialisation, hold-low tail.
// Optional statistics counters are enabled by defining USB_PD_BMC_TX_STATS_EN.
module usb_pd_bmc_tx #(
    parameter int system_khz    = 200000,
    parameter int bit_khz       = 300,
    parameter int preamble_bits = 64,
    parameter int hold_low_hb   = 4
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] symbol_data,
    input  logic       symbol_valid,
    input  logic       symbol_last,
    output logic       symbol_ready,
    output logic       busy,
    output logic       done,
    output logic       underrun,
    output logic       bmc_dout,
    output logic       bmc_oe
`ifdef USB_PD_BMC_TX_STATS_EN
    ,
    output logic [15:0] frame_count,
    output logic [7:0]  underrun_count
`endif
);

    localparam int HB  = system_khz / (2 * bit_khz);
    localparam int HBW = (HB > 1) ? $clog2(HB) : 1;
    localparam int IW  = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_TAIL     = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [HBW-1:0]  hb_cnt_r, hb_cnt_s;
    logic            half_r, half_s;
    logic [IW-1:0]   idx_r, idx_s;
    logic [4:0]      sym_r, sym_s;
    logic            last_r, last_s;
    logic            urun_r, urun_s;
    logic            dout_s, oe_s, busy_s, ready_s, done_s, underrun_s;
    logic            hb_end_s, bit_end_s, cur_bit_s;

    // Next-state, counter and next-output computation for the cycle that follows.
    always_comb begin
        state_s    = state_r;
        hb_cnt_s   = hb_cnt_r;
        half_s     = half_r;
        idx_s      = idx_r;
        sym_s      = sym_r;
        last_s     = last_r;
        urun_s     = urun_r;
        dout_s     = bmc_dout;
        oe_s       = bmc_oe;
        busy_s     = busy;
        done_s     = 1'b0;
        underrun_s = 1'b0;
        hb_end_s   = (hb_cnt_r == HBW'(HB - 1));
        bit_end_s  = hb_end_s && half_r;
        cur_bit_s  = (state_r == ST_PREAMBLE) ? idx_r[0] : sym_r[0];

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s  = ST_PREAMBLE;
                    hb_cnt_s = '0;
                    half_s   = 1'b0;
                    idx_s    = '0;
                    urun_s   = 1'b0;
                    dout_s   = 1'b1;
                    oe_s     = 1'b1;
                    busy_s   = 1'b1;
                end else begin
                    dout_s = 1'b0;
                    oe_s   = 1'b0;
                    busy_s = 1'b0;
                end
            end
            ST_PREAMBLE, ST_DATA: begin
                if (hb_end_s) begin
                    hb_cnt_s = '0;
                    half_s   = ~half_r;
                end else begin
                    hb_cnt_s = hb_cnt_r + HBW'(1);
                end
                // Every bit boundary toggles; a '1' also toggles at its half-bit boundary.
                if (!bit_end_s) begin
                    if (hb_end_s && cur_bit_s) begin
                        dout_s = ~bmc_dout;
                    end else begin
                        dout_s = bmc_dout;
                    end
                end else if (symbol_ready) begin
                    if (symbol_valid) begin
                        state_s = ST_DATA;
                        idx_s   = '0;
                        sym_s   = symbol_data;
                        last_s  = symbol_last;
                        dout_s  = ~bmc_dout;
                    end else begin
                        state_s    = ST_TAIL;
                        idx_s      = '0;
                        underrun_s = 1'b1;
                        urun_s     = 1'b1;
                        dout_s     = 1'b0;
                    end
                end else if (state_r == ST_DATA && idx_r == IW'(4) && last_r) begin
                    state_s = ST_TAIL;
                    idx_s   = '0;
                    dout_s  = 1'b0;
                end else begin
                    idx_s  = idx_r + IW'(1);
                    dout_s = ~bmc_dout;
                    if (state_r == ST_DATA) begin
                        sym_s = sym_r >> 1;
                    end else begin
                        sym_s = sym_r;
                    end
                end
            end
            ST_TAIL: begin
                dout_s = 1'b0;
                if (hb_end_s) begin
                    hb_cnt_s = '0;
                    if (idx_r == IW'(hold_low_hb - 1)) begin
                        state_s = ST_IDLE;
                        idx_s   = '0;
                        oe_s    = 1'b0;
                        busy_s  = 1'b0;
                        done_s  = ~urun_r;
                    end else begin
                        idx_s = idx_r + IW'(1);
                    end
                end else begin
                    hb_cnt_s = hb_cnt_r + HBW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                dout_s  = 1'b0;
                oe_s    = 1'b0;
                busy_s  = 1'b0;
            end
        endcase

        // Strobe ready in the final cycle of the last preamble bit or of bit 4 of a non-last symbol.
        if (half_s && hb_cnt_s == HBW'(HB - 1) &&
            ((state_s == ST_PREAMBLE && idx_s == IW'(preamble_bits - 1)) ||
             (state_s == ST_DATA && idx_s == IW'(4) && !last_s))) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            hb_cnt_r     <= '0;
            half_r       <= 1'b0;
            idx_r        <= '0;
            sym_r        <= 5'd0;
            last_r       <= 1'b0;
            urun_r       <= 1'b0;
            bmc_dout     <= 1'b0;
            bmc_oe       <= 1'b0;
            busy         <= 1'b0;
            symbol_ready <= 1'b0;
            done         <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state_r      <= state_s;
            hb_cnt_r     <= hb_cnt_s;
            half_r       <= half_s;
            idx_r        <= idx_s;
            sym_r        <= sym_s;
            last_r       <= last_s;
            urun_r       <= urun_s;
            bmc_dout     <= dout_s;
            bmc_oe       <= oe_s;
            busy         <= busy_s;
            symbol_ready <= ready_s;
            done         <= done_s;
            underrun     <= underrun_s;
        end
    end

`ifdef USB_PD_BMC_TX_STATS_EN
    // Saturating frame and underrun counters, updated in the same cycle as their pulses.
    always_ff @(posedge clock) begin
        if (rst) begin
            frame_count    <= 16'd0;
            underrun_count <= 8'd0;
        end else begin
            if (done_s && frame_count != 16'hFFFF) begin
                frame_count <= frame_count + 16'd1;
            end else begin
                frame_count <= frame_count;
            end
            if (underrun_s && underrun_count != 8'hFF) begin
                underrun_count <= underrun_count + 8'd1;
            end else begin
                underrun_count <= underrun_count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_usb_pd_bmc_tx.sv
// Self-checking bench for usb_pd_bmc_tx: per-cycle comparison against a waveform model built from bit lists.
module tb_usb_pd_bmc_tx;
    localparam int HB   = 10;
    localparam int PB   = 64;
    localparam int HL   = 4;
    localparam int MAXC = 2048;

    logic       clock = 1'b0;
    logic       rst, start, symbol_valid, symbol_last;
    logic [4:0] symbol_data;
    logic       symbol_ready, busy, done, underrun, bmc_dout, bmc_oe;
`ifdef USB_PD_BMC_TX_STATS_EN
    logic [15:0] frame_count;
    logic [7:0]  underrun_count;
`endif

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [5:0] exp_v [MAXC];
    logic       obs_dout [MAXC];
    int         exp_len, tail_t;
    logic [4:0] sym_q [8];
    int         sym_n, valid_n;
    bit         under;
    int         strobe_t[$];
    int         busy_cycles, done_cnt, urun_cnt, pre_trans;

    always #5 clock = ~clock;

    usb_pd_bmc_tx #(
        .system_khz(6000), .bit_khz(300), .preamble_bits(PB), .hold_low_hb(HL)
    ) dut (
        .clock(clock), .rst(rst), .start(start),
        .symbol_data(symbol_data), .symbol_valid(symbol_valid), .symbol_last(symbol_last),
        .symbol_ready(symbol_ready), .busy(busy), .done(done), .underrun(underrun),
        .bmc_dout(bmc_dout), .bmc_oe(bmc_oe)
`ifdef USB_PD_BMC_TX_STATS_EN
        , .frame_count(frame_count), .underrun_count(underrun_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected {busy,oe,dout,ready,done,underrun} per cycle from the frame's bit list.
    function automatic void build_model();
        int bits[$];
        int nsym, lvl, t0, last_j;
        for (int i = 0; i < PB; i++) bits.push_back(i % 2);
        nsym = under ? valid_n : sym_n;
        for (int s = 0; s < nsym; s++) begin
            logic [4:0] sv;
            sv = sym_q[s];
            for (int b = 0; b < 5; b++) bits.push_back(int'(sv[b]));
        end
        tail_t  = bits.size() * 2 * HB;
        exp_len = tail_t + HL * HB;
        for (int t = 0; t < MAXC; t++) exp_v[t] = 6'd0;
        lvl = 0;
        for (int b = 0; b < bits.size(); b++) begin
            t0  = b * 2 * HB;
            lvl = 1 - lvl;
            for (int c = 0; c < HB; c++) exp_v[t0 + c][3] = lvl[0];
            if (bits[b] == 1) lvl = 1 - lvl;
            for (int c = 0; c < HB; c++) exp_v[t0 + HB + c][3] = lvl[0];
        end
        for (int t = 0; t < exp_len; t++) begin
            exp_v[t][5] = 1'b1;
            exp_v[t][4] = 1'b1;
        end
        last_j = under ? valid_n : sym_n - 1;
        for (int j = 0; j <= last_j; j++) exp_v[(PB + 5 * j) * 2 * HB - 1][2] = 1'b1;
        if (under) exp_v[tail_t][0] = 1'b1;
        else       exp_v[exp_len][1] = 1'b1;
    endfunction

    task automatic run_frame(input int poke_t);
        int k;
        logic prev;
        build_model();
        strobe_t.delete();
        busy_cycles = 0; done_cnt = 0; urun_cnt = 0; pre_trans = 0;
        prev = 1'b0;
        k = 0;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        for (int t = 0; t <= exp_len + 3; t++) begin
            if (t > 0) @(negedge clock);
            check($sformatf("cyc%0d", t), {busy, bmc_oe, bmc_dout, symbol_ready, done, underrun}, exp_v[t]);
            obs_dout[t] = bmc_dout;
            busy_cycles += int'(busy);
            done_cnt    += int'(done);
            urun_cnt    += int'(underrun);
            if (t < PB * 2 * HB && bmc_dout !== prev) pre_trans++;
            prev = bmc_dout;
            start        = (t == poke_t);
            symbol_data  = sym_q[k % 8];
            symbol_valid = !under || (k < valid_n);
            symbol_last  = !under && (k == sym_n - 1);
            if (symbol_ready === 1'b1) begin
                strobe_t.push_back(t);
                k++;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        logic [9:0] cap;
        int zeros;
        rst = 1'b1; start = 1'b0; symbol_data = 5'd0; symbol_valid = 1'b0; symbol_last = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outs", {busy, bmc_oe, bmc_dout, symbol_ready, done, underrun}, 6'd0);
        rst = 1'b0;

        // Two symbols, ready strobe timing and decoded data bits.
        sym_q[0] = 5'b11000; sym_q[1] = 5'b01101; sym_n = 2; under = 1'b0; valid_n = 0;
        run_frame(-1);
        check("strobe0", strobe_t.size() > 0 ? strobe_t[0] : -1, 1279);
        check("strobe1", strobe_t.size() > 1 ? strobe_t[1] : -1, 1379);
        check("pre_trans", pre_trans, 96);
        check("done_cnt1", done_cnt, 1);
        for (int i = 0; i < 10; i++) begin
            int t0;
            t0 = 1280 + 20 * i;
            cap[i] = obs_dout[t0 + HB - 1] ^ obs_dout[t0 + HB];
        end
        check("data_bits", cap, 10'b0110111000);

        // Three symbols with a start pulse mid-DATA that must be ignored.
        sym_q[0] = 5'b10110; sym_q[1] = 5'b00111; sym_q[2] = 5'b01101; sym_n = 3;
        run_frame(1350);
        check("busy_len", busy_cycles, 1620);
        check("done_cnt3", done_cnt, 1);
        zeros = 0;
        for (int t = 1580; t < 1620; t++) zeros += int'(obs_dout[t] == 1'b0);
        check("tail_zero", zeros, 40);

        // Last symbol leaves the line high, so TAIL must pull it low.
        sym_q[0] = 5'b11000; sym_q[1] = 5'b00001; sym_n = 2;
        run_frame(-1);
        check("pre_tail_hi", obs_dout[tail_t - 1], 1'b1);
        check("tail_lo", obs_dout[tail_t], 1'b0);

        // Reset in the middle of the preamble.
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        repeat (600) @(negedge clock);
        rst = 1'b1;
        @(negedge clock);
        check("rst_mid", {busy, bmc_oe, bmc_dout, symbol_ready, done, underrun}, 6'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check($sformatf("post_rst%0d", i), {busy, bmc_oe, bmc_dout, done}, 4'd0);
        end

        // Underrun at the first data strobe.
        sym_q[0] = 5'b11000; sym_n = 2; under = 1'b1; valid_n = 0;
        run_frame(-1);
        check("urun_cnt", urun_cnt, 1);
        check("urun_done", done_cnt, 0);
        check("urun_strobes", strobe_t.size(), 1);
`ifdef USB_PD_BMC_TX_STATS_EN
        check("stat_urun", underrun_count, 8'd1);
        check("stat_frames", frame_count, 16'd0);
`endif

        // Randomised frames, some ending in underrun.
        for (int f = 0; f < 4; f++) begin
            sym_n = $urandom_range(1, 4);
            for (int s = 0; s < 8; s++) sym_q[s] = 5'($urandom_range(0, 31));
            under   = ($urandom_range(0, 2) == 0);
            valid_n = $urandom_range(0, sym_n - 1);
            run_frame(f == 1 ? 1400 : -1);
            check($sformatf("rnd%0d_done", f), done_cnt, under ? 0 : 1);
            check($sformatf("rnd%0d_urun", f), urun_cnt, under ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
